// File: rtl/lfsr_checker.sv
// Lock/track checker for the 8-bit team LFSR sequence with a saturating error count.
// Optional: define LFSR_CHECKER_STUCK_DETECT_EN to drop lock at once on an all-zero sample.
module lfsr_checker #(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    input  logic [7:0]       i_value,
    input  logic             i_clear,
    output logic             o_locked,
    output logic             o_error,
    output logic [CNT_W-1:0] o_err_count
);

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    localparam logic [3:0] LOCK_C   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_C = 4'(UNLOCK_CNT);

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    state_t     state;
    logic [7:0] prev;
    logic       prev_vld;
    logic [7:0] expected;
    logic [3:0] match_cnt;
    logic [3:0] miss_cnt;

    logic       hunt_hit;
    logic       lock_miss;
    logic       stuck;
    logic       cnt_full;
    logic [3:0] match_inc;
    logic [3:0] miss_inc;

    always_comb begin
        hunt_hit  = prev_vld && (i_value != 8'h00)
                    && (i_value == lfsr_next(prev));
        lock_miss = (i_value != expected);
        match_inc = match_cnt + 4'd1;
        miss_inc  = miss_cnt + 4'd1;
        cnt_full  = (o_err_count == {CNT_W{1'b1}});
`ifdef LFSR_CHECKER_STUCK_DETECT_EN
        stuck     = (i_value == 8'h00);
`else
        stuck     = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            prev        <= 8'h00;
            prev_vld    <= 1'b0;
            expected    <= 8'h00;
            match_cnt   <= 4'd0;
            miss_cnt    <= 4'd0;
            o_locked    <= 1'b0;
            o_error     <= 1'b0;
            o_err_count <= '0;
        end else begin
            o_error <= 1'b0;
            if (i_valid) begin
                unique case (state)
                    HUNT: begin
                        prev     <= i_value;
                        prev_vld <= 1'b1;
                        if (hunt_hit && match_inc == LOCK_C) begin
                            state     <= LOCKED;
                            o_locked  <= 1'b1;
                            expected  <= lfsr_next(i_value);
                            match_cnt <= 4'd0;
                            miss_cnt  <= 4'd0;
                        end else if (hunt_hit) begin
                            match_cnt <= match_inc;
                        end else begin
                            match_cnt <= 4'd0;
                        end
                    end
                    LOCKED: begin
                        // prediction free-runs so bad samples never corrupt it
                        expected <= lfsr_next(expected);
                        if (lock_miss) begin
                            o_error <= 1'b1;
                            if (!cnt_full) begin
                                o_err_count <= o_err_count + CNT_W'(1);
                            end
                            if (miss_inc == UNLOCK_C || stuck) begin
                                state     <= HUNT;
                                o_locked  <= 1'b0;
                                match_cnt <= 4'd0;
                                miss_cnt  <= 4'd0;
                                prev_vld  <= 1'b0;
                            end else begin
                                miss_cnt <= miss_inc;
                            end
                        end else begin
                            miss_cnt <= 4'd0;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
            if (i_clear) begin
                o_err_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: expected outputs queued at drive time,
// observed outputs queued one edge later, each scenario drains and compares.
module tb_lfsr_checker;

    typedef struct packed {
        logic        l;
        logic        e;
        logic [15:0] c;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic [7:0]  i_value;
    logic        i_clear;
    logic        o_locked;
    logic        o_error;
    logic [15:0] o_err_count;

    int   checks;
    int   failures;
    res_t exp_q[$];
    res_t obs_q[$];
    logic [7:0]  cur;
    logic [15:0] ecnt;

    lfsr_checker dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (i_valid),
        .i_value     (i_value),
        .i_clear     (i_clear),
        .o_locked    (o_locked),
        .o_error     (o_error),
        .o_err_count (o_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] nx(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [7:0] bad(input logic [7:0] v);
        logic [7:0] w;
        w = v ^ 8'h01;
        if (w == 8'h00) w = 8'h03;
        return w;
    endfunction

    task automatic send(input logic v, input logic [7:0] val, input logic clr,
                        input logic el, input logic ee, input logic [15:0] ec);
        @(negedge clk);
        i_valid = v;
        i_value = val;
        i_clear = clr;
        exp_q.push_back('{l: el, e: ee, c: ec});
        @(posedge clk);
        #1;
        obs_q.push_back('{l: o_locked, e: o_error, c: o_err_count});
        i_valid = 1'b0;
        i_clear = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        ecnt = 16'd0;
    endtask

    task automatic lock_stream();
        logic [7:0] tbl [5];
        tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
        for (int i = 0; i < 5; i++) begin
            send(1'b1, tbl[i], 1'b0, i == 4, 1'b0, ecnt);
        end
        cur = 8'h11;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_value = 8'h00;
        i_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks += 3;
        if (o_locked !== 1'b0) begin
            failures++;
            $display("FAIL reset_locked: got %b want 0", o_locked);
        end
        if (o_error !== 1'b0) begin
            failures++;
            $display("FAIL reset_error: got %b want 0", o_error);
        end
        if (o_err_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_count: got %0d want 0", o_err_count);
        end
        rst_n = 1'b1;
        ecnt = 16'd0;
    endtask

    task automatic test_lock();
        res_t e, o;
        lock_stream();
        cur = nx(cur);
        send(1'b1, cur, 1'b0, 1'b1, 1'b0, ecnt);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL lock: got l=%b e=%b c=%0d want l=%b e=%b c=%0d",
                         o.l, o.e, o.c, e.l, e.e, e.c);
            end
        end
    endtask

    task automatic test_single_error();
        res_t e, o;
        do_reset();
        lock_stream();
        cur = nx(cur);
        ecnt++;
        send(1'b1, 8'h24, 1'b0, 1'b1, 1'b1, ecnt);
        for (int i = 0; i < 4; i++) begin
            cur = nx(cur);
            send(1'b1, cur, 1'b0, 1'b1, 1'b0, ecnt);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL single_err: got l=%b e=%b c=%0d want l=%b e=%b c=%0d",
                         o.l, o.e, o.c, e.l, e.e, e.c);
            end
        end
    endtask

    task automatic test_loss_of_lock();
        res_t e, o;
        for (int i = 0; i < 3; i++) begin
            cur = nx(cur);
            ecnt++;
            send(1'b1, bad(cur), 1'b0, i < 2, 1'b1, ecnt);
        end
        for (int i = 0; i < 6; i++) begin
            cur = nx(cur);
            send(1'b1, cur, 1'b0, i >= 4, 1'b0, ecnt);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL unlock: got l=%b e=%b c=%0d want l=%b e=%b c=%0d",
                         o.l, o.e, o.c, e.l, e.e, e.c);
            end
        end
    endtask

    task automatic test_gaps_clear();
        res_t e, o;
        for (int i = 0; i < 6; i++) begin
            send(1'b0, 8'($urandom_range(255)), 1'b0, 1'b1, 1'b0, ecnt);
            cur = nx(cur);
            send(1'b1, cur, 1'b0, 1'b1, 1'b0, ecnt);
        end
        cur = nx(cur);
        ecnt = 16'd0;
        send(1'b1, bad(cur), 1'b1, 1'b1, 1'b1, ecnt);
        cur = nx(cur);
        send(1'b1, cur, 1'b0, 1'b1, 1'b0, ecnt);
        cur = nx(cur);
        ecnt++;
        send(1'b1, bad(cur), 1'b0, 1'b1, 1'b1, ecnt);
        cur = nx(cur);
        ecnt = 16'd0;
        send(1'b1, cur, 1'b1, 1'b1, 1'b0, ecnt);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL gap_clear: got l=%b e=%b c=%0d want l=%b e=%b c=%0d",
                         o.l, o.e, o.c, e.l, e.e, e.c);
            end
        end
    endtask

    task automatic test_reset_midstream();
        res_t e, o;
        cur = nx(cur);
        ecnt++;
        send(1'b1, bad(cur), 1'b0, 1'b1, 1'b1, ecnt);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_locked, o_error, o_err_count} !== 18'd0) begin
            failures++;
            $display("FAIL async_reset: got l=%b e=%b c=%0d want all 0",
                     o_locked, o_error, o_err_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ecnt = 16'd0;
        for (int i = 0; i < 5; i++) begin
            cur = nx(cur);
            send(1'b1, cur, 1'b0, i == 4, 1'b0, ecnt);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL relock: got l=%b e=%b c=%0d want l=%b e=%b c=%0d",
                         o.l, o.e, o.c, e.l, e.e, e.c);
            end
        end
    endtask

    task automatic test_stuck();
        res_t e, o;
        logic stay;
`ifdef LFSR_CHECKER_STUCK_DETECT_EN
        stay = 1'b0;
`else
        stay = 1'b1;
`endif
        cur = nx(cur);
        ecnt++;
        send(1'b1, 8'h00, 1'b0, stay, 1'b1, ecnt);
        cur = nx(cur);
        send(1'b1, cur, 1'b0, stay, 1'b0, ecnt);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL stuck: got l=%b e=%b c=%0d want l=%b e=%b c=%0d",
                         o.l, o.e, o.c, e.l, e.e, e.c);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cur      = 8'h00;
        ecnt     = 16'd0;
        test_reset();
        test_lock();
        test_single_error();
        test_loss_of_lock();
        test_gaps_clear();
        test_reset_midstream();
        test_stuck();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
